// File: rtl/bat_amateur_reg_file.sv
// bat_amateur_reg_file: eight-entry general register file for the BatAmateur
// controller. Registers 0/1 feed the ALU, register 7 (OUT) streams every new
// value into a valid/ready output FIFO. Bus reads go through a priority mux.
// Optional build macro BAT_REGFILE_BUS_CONFLICT_EN adds a sticky BUS_CONFLICT
// output and zeroes BUS_OUT whenever more than one register drives the bus.
module bat_amateur_reg_file #(
    parameter int WIDTH     = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [7:0]                   REGS_INC,
    input  logic [7:0]                   REGS_RW,
    input  logic [7:0]                   REGS_EN,
    input  logic [WIDTH-1:0]             BUS_IN,
    output logic [WIDTH-1:0]             BUS_OUT,
    output logic                         BUS_OUT_VALID,
    output logic [WIDTH-1:0]             A_OUT,
    output logic [WIDTH-1:0]             B_OUT,
    output logic [WIDTH-1:0]             OUT_DATA,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [$clog2(OUT_DEPTH):0]   OUT_COUNT,
`ifdef BAT_REGFILE_BUS_CONFLICT_EN
    output logic                         BUS_CONFLICT,
`endif
    output logic                         OUT_OVF
);

    localparam int PW = $clog2(OUT_DEPTH);

    logic [WIDTH-1:0] regs     [8];
    logic [WIDTH-1:0] regs_nxt [8];
    logic [7:0]       reg_upd;

    logic [WIDTH-1:0] rd_data;
    logic             rd_any;
    logic             rd_multi;

    logic [WIDTH-1:0] fifo_mem [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             ovf;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;

    // Per-register next value: a bus load beats increment, otherwise hold.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            regs_nxt[i] = regs[i];
            reg_upd[i]  = 1'b0;
            if (REGS_EN[i]) begin
                if (!REGS_RW[i]) begin
                    regs_nxt[i] = BUS_IN;
                    reg_upd[i]  = 1'b1;
                end
            end else if (REGS_INC[i]) begin
                regs_nxt[i] = regs[i] + WIDTH'(1);
                reg_upd[i]  = 1'b1;
            end
        end
    end

    // Register storage.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (reg_upd[i]) regs[i] <= regs_nxt[i];
            end
        end
    end

    // Bus read mux: lowest-index reading register wins; flag multiple readers.
    always_comb begin
        rd_data  = '0;
        rd_any   = 1'b0;
        rd_multi = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (REGS_EN[i] && REGS_RW[i]) begin
                if (!rd_any) rd_data = regs[i];
                else         rd_multi = 1'b1;
                rd_any = 1'b1;
            end
        end
    end

`ifdef BAT_REGFILE_BUS_CONFLICT_EN
    assign BUS_OUT = rd_multi ? '0 : rd_data;

    // Sticky record of any cycle with more than one bus driver.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)          BUS_CONFLICT <= 1'b0;
        else if (rd_multi) BUS_CONFLICT <= 1'b1;
    end
`else
    assign BUS_OUT = rd_data;
`endif

    assign BUS_OUT_VALID = rd_any;
    assign A_OUT         = regs[0];
    assign B_OUT         = regs[1];

    // FIFO control: a push into a full FIFO is accepted only alongside a pop.
    assign push   = reg_upd[7];
    assign pop    = OUT_VALID && OUT_READY;
    assign full   = (count == (PW+1)'(OUT_DEPTH));
    assign accept = push && (!full || pop);

    // Output FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                fifo_mem[wr_ptr] <= regs_nxt[7];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)      count <= count + (PW+1)'(1);
            else if (!accept && pop) count <= count - (PW+1)'(1);
            if (push && full && !pop) ovf <= 1'b1;
        end
    end

    assign OUT_VALID = (count != '0);
    assign OUT_DATA  = OUT_VALID ? fifo_mem[rd_ptr] : '0;
    assign OUT_COUNT = count;
    assign OUT_OVF   = ovf;

endmodule

// File: tb/tb_bat_amateur_reg_file.sv
// Directed self-checking bench for bat_amateur_reg_file.
module tb_bat_amateur_reg_file;

    logic       CLK;
    logic       RST;
    logic [7:0] REGS_INC;
    logic [7:0] REGS_RW;
    logic [7:0] REGS_EN;
    logic [7:0] bus_in_drv;
    logic       tie_bus;
    logic [7:0] BUS_IN;
    logic [7:0] BUS_OUT;
    logic       BUS_OUT_VALID;
    logic [7:0] A_OUT;
    logic [7:0] B_OUT;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [2:0] OUT_COUNT;
    logic       OUT_OVF;
`ifdef BAT_REGFILE_BUS_CONFLICT_EN
    logic       BUS_CONFLICT;
`endif

    int total = 0;
    int bad   = 0;

    assign BUS_IN = tie_bus ? BUS_OUT : bus_in_drv;

    bat_amateur_reg_file #(.WIDTH(8), .OUT_DEPTH(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .REGS_INC(REGS_INC),
        .REGS_RW(REGS_RW),
        .REGS_EN(REGS_EN),
        .BUS_IN(BUS_IN),
        .BUS_OUT(BUS_OUT),
        .BUS_OUT_VALID(BUS_OUT_VALID),
        .A_OUT(A_OUT),
        .B_OUT(B_OUT),
        .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OUT_COUNT(OUT_COUNT),
`ifdef BAT_REGFILE_BUS_CONFLICT_EN
        .BUS_CONFLICT(BUS_CONFLICT),
`endif
        .OUT_OVF(OUT_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        REGS_EN  = 8'h00;
        REGS_RW  = 8'hFF;
        REGS_INC = 8'h00;
    endtask

    // Drive a bus read of one register and check the combinational result.
    task automatic rd(input int idx, input logic [7:0] exp, input string tag);
        REGS_INC = 8'h00;
        REGS_RW  = 8'hFF;
        REGS_EN  = 8'h01 << idx;
        #1;
        chk(tag, BUS_OUT, exp);
        idle();
    endtask

    // Load one register from the bus on the next edge.
    task automatic wr(input int idx, input logic [7:0] val);
        REGS_INC   = 8'h00;
        REGS_EN    = 8'h01 << idx;
        REGS_RW    = ~(8'h01 << idx);
        bus_in_drv = val;
        tick();
        idle();
    endtask

    initial begin
        RST        = 1'b0;
        tie_bus    = 1'b0;
        bus_in_drv = 8'h00;
        OUT_READY  = 1'b0;
        idle();
        tick();
        chk("rst_a", A_OUT, 8'h00);
        chk("rst_b", B_OUT, 8'h00);
        chk("rst_bus", BUS_OUT, 8'h00);
        chk("rst_busv", BUS_OUT_VALID, 1'b0);
        chk("rst_valid", OUT_VALID, 1'b0);
        chk("rst_count", OUT_COUNT, 3'd0);
        chk("rst_ovf", OUT_OVF, 1'b0);
        chk("rst_data", OUT_DATA, 8'h00);
        RST = 1'b1;
        tick();

        // Load then read
        wr(2, 8'h5A);
        REGS_EN = 8'h04; REGS_RW = 8'hFF; #1;
        chk("load_read", BUS_OUT, 8'h5A);
        chk("load_readv", BUS_OUT_VALID, 1'b1);
        idle(); #1;
        chk("idle_busv", BUS_OUT_VALID, 1'b0);

        // MOV reg3 -> reg2 with BUS_IN tied to BUS_OUT
        wr(2, 8'h11);
        wr(3, 8'h22);
        tie_bus = 1'b1;
        REGS_EN = 8'h0C; REGS_RW = 8'hFB; #1;
        chk("mov_bus", BUS_OUT, 8'h22);
        tick();
        tie_bus = 1'b0;
        idle();
        rd(2, 8'h22, "mov_r2");
        rd(3, 8'h22, "mov_r3");

        // Multi-load, ALU outputs, read priority
        REGS_EN = 8'h03; REGS_RW = 8'hFC; bus_in_drv = 8'h3C;
        tick(); idle();
        chk("multi_a", A_OUT, 8'h3C);
        chk("multi_b", B_OUT, 8'h3C);
        wr(1, 8'hC3);
        chk("b_out", B_OUT, 8'hC3);
        REGS_EN = 8'h03; REGS_RW = 8'hFF; #1;
`ifdef BAT_REGFILE_BUS_CONFLICT_EN
        chk("prio_bus", BUS_OUT, 8'h00);
        tick();
        chk("conflict", BUS_CONFLICT, 1'b1);
`else
        chk("prio_bus", BUS_OUT, 8'h3C);
`endif
        idle();
        REGS_INC = 8'h01; tick(); idle();
        chk("inc_a", A_OUT, 8'h3D);

        // Increment wrap and EN-over-INC
        wr(5, 8'hFF);
        REGS_INC = 8'h20; tick(); idle();
        rd(5, 8'h00, "inc_wrap");
        REGS_INC = 8'h20; REGS_EN = 8'h20; REGS_RW = 8'hDF; bus_in_drv = 8'h07;
        tick(); idle();
        rd(5, 8'h07, "en_over_inc");
        REGS_INC = 8'h20; REGS_EN = 8'h20; REGS_RW = 8'hFF;
        tick(); idle();
        rd(5, 8'h07, "read_over_inc");

        // FIFO fill and overflow
        OUT_READY = 1'b0;
        wr(7, 8'h01);
        chk("fifo_valid1", OUT_VALID, 1'b1);
        chk("fifo_cnt1", OUT_COUNT, 3'd1);
        chk("fifo_head1", OUT_DATA, 8'h01);
        wr(7, 8'h02);
        wr(7, 8'h03);
        wr(7, 8'h04);
        chk("fifo_ovf_pre", OUT_OVF, 1'b0);
        wr(7, 8'h05);
        chk("fifo_cnt4", OUT_COUNT, 3'd4);
        chk("fifo_ovf", OUT_OVF, 1'b1);
        chk("fifo_hold", OUT_DATA, 8'h01);
        rd(7, 8'h05, "reg7_after_ovf");
        OUT_READY = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("drain", OUT_DATA, 8'(k));
            tick();
        end
        chk("drain_empty", OUT_VALID, 1'b0);
        chk("drain_cnt", OUT_COUNT, 3'd0);

        // Full with simultaneous push and pop
        OUT_READY = 1'b0;
        wr(7, 8'h10);
        wr(7, 8'h20);
        wr(7, 8'h30);
        wr(7, 8'h40);
        OUT_READY = 1'b1;
        wr(7, 8'h99);
        chk("pp_cnt", OUT_COUNT, 3'd4);
        chk("pp_ovf", OUT_OVF, 1'b1);
        begin
            logic [7:0] exp_seq [4];
            exp_seq[0] = 8'h20; exp_seq[1] = 8'h30; exp_seq[2] = 8'h40; exp_seq[3] = 8'h99;
            for (int k = 0; k < 4; k++) begin
                chk("pp_drain", OUT_DATA, exp_seq[k]);
                tick();
            end
        end
        chk("pp_empty", OUT_VALID, 1'b0);

        // Increment of OUT pushes the new value
        OUT_READY = 1'b0;
        REGS_INC = 8'h80; tick(); idle();
        chk("inc_push_data", OUT_DATA, 8'h9A);
        chk("inc_push_cnt", OUT_COUNT, 3'd1);
        REGS_INC = 8'h80; tick(); idle();
        chk("inc_push_cnt2", OUT_COUNT, 3'd2);

        // Asynchronous reset mid-cycle
        #2;
        RST = 1'b0;
        #1;
        chk("arst_a", A_OUT, 8'h00);
        chk("arst_b", B_OUT, 8'h00);
        chk("arst_valid", OUT_VALID, 1'b0);
        chk("arst_cnt", OUT_COUNT, 3'd0);
        chk("arst_ovf", OUT_OVF, 1'b0);
        chk("arst_data", OUT_DATA, 8'h00);
        rd(5, 8'h00, "arst_r5");
        rd(7, 8'h00, "arst_r7");
        tick();
        RST = 1'b1;
        tick();
        wr(7, 8'h42);
        chk("post_rst_head", OUT_DATA, 8'h42);
        chk("post_rst_cnt", OUT_COUNT, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bat_amateur_reg_file.md
Name: bat_amateur_reg_file

Overview:
- Eight-entry general register file directly downstream of the BatAmateur controller.
- Consumes the controller's per-register REGS_INC/REGS_RW/REGS_EN strobes and exchanges data with the shared system bus. Reads are driven through a mux; there is no tristate.
- Presents registers A and B continuously to the ALU.
- Register 7 (OUT) also pushes each new value into an output FIFO, which an external sink drains with a valid/ready handshake.

Parameters:
- WIDTH, 8, data width of every register and bus.
- OUT_DEPTH, 4, output FIFO depth in entries. Power of two, minimum 2.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  asynchronous active-low reset
- REGS_INC  input  8  per-register increment strobe; bit 0=A, 1=B, 2..6=general, 7=OUT
- REGS_RW  input  8  per-register direction; 1=read (drive bus), 0=write (load from bus)
- REGS_EN  input  8  per-register bus enable
- BUS_IN  input  WIDTH  system bus value to load
- BUS_OUT  output  WIDTH  value of the selected read register; 0 when none is selected
- BUS_OUT_VALID  output  1  high when any register has EN=1 and RW=1
- A_OUT  output  WIDTH  register 0 contents, to the ALU
- B_OUT  output  WIDTH  register 1 contents, to the ALU
- OUT_DATA  output  WIDTH  FIFO head entry
- OUT_VALID  output  1  FIFO not empty
- OUT_READY  input  1  sink accepts OUT_DATA this cycle
- OUT_COUNT  output  $clog2(OUT_DEPTH)+1  FIFO occupancy
- OUT_OVF  output  1  sticky flag: a push was dropped because the FIFO was full

Behaviour:
- Reset (RST=0, asynchronous, takes effect immediately):
  - all eight registers = 0; FIFO empty; read and write pointers = 0
  - OUT_VALID=0, OUT_COUNT=0, OUT_OVF=0, OUT_DATA=0
  - BUS_OUT, A_OUT, B_OUT = 0
  - Reset takes priority over every other input.
  - Reset mid-transfer discards all FIFO contents.
- Per register i, decoded each rising edge:
  - EN[i]=1, RW[i]=0: reg[i] <= BUS_IN.
  - EN[i]=1, RW[i]=1: no state change; reg[i] is a bus read candidate.
  - EN[i]=0, INC[i]=1: reg[i] <= reg[i]+1, modulo 2^WIDTH (0xFF -> 0x00).
  - EN[i]=1 together with INC[i]=1: INC is ignored; the EN action wins.
  - EN[i]=0, INC[i]=0: hold.
- Bus read is combinational:
  - BUS_OUT = contents of the lowest-index register with EN=1 and RW=1.
  - A register that reads and is written in the same cycle by another register's load (e.g. MOV) supplies its pre-edge value.
  - Several registers may load BUS_IN in the same cycle.
- A_OUT and B_OUT are combinational from reg[0] and reg[1]. They reflect an update the cycle after the edge.
- Output FIFO:
  - Push whenever reg[7] is updated, by load or by increment; the pushed value is the new reg[7] value.
  - Pop when OUT_VALID=1 and OUT_READY=1.
  - Write to OUT at edge N: OUT_VALID goes high after edge N. There is no same-cycle bypass.
  - Push while full without a simultaneous pop: push dropped, reg[7] still updates, OUT_OVF <= 1. OUT_OVF is cleared only by reset.
  - Push and pop in the same cycle while full: both happen; OUT_COUNT unchanged; no overflow.
  - Push and pop in the same cycle while empty: impossible, since OUT_VALID=0; the push alone occurs.
  - Pointers wrap modulo OUT_DEPTH.
  - OUT_DATA is stable while OUT_VALID=1 and OUT_READY=0.
- Controller idle pattern (RW=0xFF, EN=0x00, INC=0x00): no state change; BUS_OUT_VALID=0.

Optional Feature:
- Macro: BAT_REGFILE_BUS_CONFLICT_EN.
- Defined:
  - Adds output BUS_CONFLICT (1 bit, sticky, reset 0).
  - BUS_CONFLICT is set on any edge where more than one register has EN=1 and RW=1.
  - Under conflict, BUS_OUT is forced to 0 instead of the lowest-index value.
- Undefined:
  - The port is absent.
  - Lowest-index priority applies silently.

Test Plan:
- Reset: RST=0 asynchronously with nonzero registers and 2 FIFO entries -> all registers 0, OUT_VALID=0, OUT_COUNT=0, OUT_OVF=0, with no clock edge needed.
- Load/read: BUS_IN=0x5A, EN=0x04, RW=0xFB, one edge -> then EN=0x04, RW=0xFF gives BUS_OUT=0x5A, BUS_OUT_VALID=1.
- MOV: reg2=0x11, reg3=0x22; EN=0x0C, RW=0xFB, BUS_IN tied to BUS_OUT -> after the edge reg2=0x22 and reg3=0x22.
- Increment: reg5=0xFF, INC=0x20, EN=0 -> reg5=0x00. Same cycle with EN[5]=1, RW[5]=0, BUS_IN=0x07 -> reg5=0x07.
- FIFO: OUT_READY=0; write reg7 with 0x01..0x05 on consecutive edges -> OUT_COUNT=4, OUT_OVF=1, reg7=0x05. Raise OUT_READY -> pops 0x01, 0x02, 0x03, 0x04, then OUT_VALID=0.
- Full plus simultaneous push/pop: FIFO full, OUT_READY=1, write 0x99 -> OUT_COUNT stays 4, OUT_OVF unchanged, 0x99 emerges last.
